// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor: FSM state encoding.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_full_adder_cell.sv
// One-bit full adder assembled from two half adders and an OR gate.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1, c1, c2;

    assign s1 = a ^ b;
    assign c1 = a & b;
    assign s  = s1 ^ ci;
    assign c2 = s1 & ci;
    assign co = c1 | c2;

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one result bit per clock, LSB first, through a
// single full-adder cell and a 1-bit carry register.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic         cin,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    // One extra counter bit so W = 2^k never wraps before the last compare.
    localparam int CW = $clog2(W) + 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          carry;
    logic [W-1:0]  a_sh, b_sh;
    logic [W-2:0]  acc;
    logic          fa_s, fa_co;
    logic          accept, last;

    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (cnt == CW'(W - 1));

    full_adder_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
                RUN: if (last) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Subtraction is a + ~b + 1: invert b at load and seed the carry with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            carry <= sub ? 1'b1 : cin;
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            acc   <= '0;
        end else if (state == RUN) begin
            cnt   <= cnt + CW'(1);
            carry <= fa_co;
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            acc   <= (W-1)'({fa_s, acc} >> 1);
            if (last) begin
                sum  <= {fa_s, acc};
                cout <= fa_co;
                ovf  <= carry ^ fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench: drivers push expected results, negedge monitors pop on done.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic       start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         edge_n;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    serial_addsub #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .cin(cin8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
        .cout(cout8), .ovf(ovf8)
    );

    serial_addsub #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .cin(cin4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .sum(sum4),
        .cout(cout4), .ovf(ovf4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // At a negedge, cyc-1 is the index of the edge that just produced done.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL done8_unexpected: done at edge %0d with nothing pending", cyc - 1);
            end else begin
                e = q8.pop_front();
                if (sum8 !== e.sum || cout8 !== e.cout || ovf8 !== e.ovf || cyc - 1 != e.edge_n) begin
                    errors++;
                    $display("FAIL w8_result: got sum=%h cout=%b ovf=%b edge=%0d expected sum=%h cout=%b ovf=%b edge=%0d",
                             sum8, cout8, ovf8, cyc - 1, e.sum, e.cout, e.ovf, e.edge_n);
                end
            end
        end
        if (rst_n && done4) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL done4_unexpected: done at edge %0d with nothing pending", cyc - 1);
            end else begin
                e = q4.pop_front();
                if (sum4 !== e.sum[3:0] || cout4 !== e.cout || ovf4 !== e.ovf || cyc - 1 != e.edge_n) begin
                    errors++;
                    $display("FAIL w4_result: got sum=%h cout=%b ovf=%b edge=%0d expected sum=%h cout=%b ovf=%b edge=%0d",
                             sum4, cout4, ovf4, cyc - 1, e.sum[3:0], e.cout, e.ovf, e.edge_n);
                end
            end
        end
    end

    task automatic wait_idle8();
        int n = 0;
        @(negedge clk);
        while (busy8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy8) chk("w8_idle_timeout", 64'(busy8), 64'd0);
    endtask

    task automatic wait_idle4();
        int n = 0;
        @(negedge clk);
        while (busy4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy4) chk("w4_idle_timeout", 64'(busy4), 64'd0);
    endtask

    // done appears on the W-th edge after the accepting edge.
    task automatic op8(input logic s, input logic ci, input logic [7:0] aa, input logic [7:0] bb,
                       input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        wait_idle8();
        sub8 = s; cin8 = ci; a8 = aa; b8 = bb; start8 = 1'b1;
        @(posedge clk);
        e.sum = es; e.cout = ec; e.ovf = eo; e.edge_n = cyc + 8;
        q8.push_back(e);
        #1;
        start8 = 1'b0;
        a8 = ~aa; b8 = ~bb; sub8 = ~s; cin8 = ~ci;
    endtask

    task automatic op4(input logic s, input logic ci, input logic [3:0] aa, input logic [3:0] bb);
        exp_t e;
        logic [3:0] bx;
        logic [4:0] full;
        bx   = s ? ~bb : bb;
        full = {1'b0, aa} + {1'b0, bx} + {4'd0, (s ? 1'b1 : ci)};
        wait_idle4();
        sub4 = s; cin4 = ci; a4 = aa; b4 = bb; start4 = 1'b1;
        @(posedge clk);
        e.sum    = {4'd0, full[3:0]};
        e.cout   = full[4];
        e.ovf    = (aa[3] == bx[3]) && (full[3] != aa[3]);
        e.edge_n = cyc + 4;
        q4.push_back(e);
        #1;
        start4 = 1'b0;
        a4 = ~aa; b4 = ~bb;
    endtask

    initial begin
        int base;
        int n;
        repeat (2) @(negedge clk);
        chk("reset_busy8", 64'(busy8), 64'd0);
        chk("reset_done8", 64'(done8), 64'd0);
        chk("reset_sum8", 64'(sum8), 64'd0);
        chk("reset_flags8", 64'({cout8, ovf8}), 64'd0);
        chk("reset_w4", 64'({busy4, done4, sum4, cout4, ovf4}), 64'd0);
        rst_n = 1'b1;

        op8(1'b0, 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
        op8(1'b0, 1'b1, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0);
        op8(1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
        op8(1'b1, 1'b0, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0);
        op8(1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        op8(1'b1, 1'b1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0);

        // start held high: accepts every W+2 edges, nothing queued in between
        wait_idle8();
        base = cyc;
        sub8 = 1'b0; cin8 = 1'b0; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        for (int k = 0; k < 3; k++) q8.push_back('{8'h46, 1'b0, 1'b0, base + 10 * k + 8});
        repeat (30) @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        chk("held_start_busy", 64'(busy8), 64'd0);

        // reset during RUN aborts with no done pulse
        wait_idle8();
        sub8 = 1'b0; cin8 = 1'b0; a8 = 8'hA5; b8 = 8'h11; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy8), 64'd0);
        chk("abort_sum", 64'(sum8), 64'd0);
        chk("abort_flags", 64'({done8, cout8, ovf8}), 64'd0);
        q8.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op8(1'b0, 1'b0, 8'd3, 8'd4, 8'd7, 1'b0, 1'b0);

        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++)
                        op4(s[0], c[0], x[3:0], y[3:0]);

        n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain_q8", 64'(q8.size()), 64'd0);
        chk("drain_q4", 64'(q4.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
